fsm_count_seq: RTL and testbench

//  Parametrised Moore counting sequencer for icestick button/LED designs.
//  A go press starts a count, up or down, over [0, MAX_COUNT] on led; done_sig then pulses.

---
 rtl/fsm_count_seq_if.sv | 22 ++
 rtl/fsm_count_seq.sv | 172 +++++++++++++++++
 tb/tb_fsm_count_seq.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fsm_count_seq_if.sv
// Button/LED bundle for fsm_count_seq.
// The master side drives the active-low buttons and dir; the slave side (the sequencer) drives the outputs.
interface fsm_count_seq_if #(
  parameter int CNT_WIDTH = 4
);
  logic                 go_btn;
  logic                 stop_btn;
  logic                 dir;
  logic [CNT_WIDTH-1:0] led;
  logic                 done_sig;
  logic                 busy;

  modport master (
    output go_btn, stop_btn, dir,
    input  led, done_sig, busy
  );

  modport slave (
    input  go_btn, stop_btn, dir,
    output led, done_sig, busy
  );
endinterface

// File: rtl/fsm_count_seq.sv
// Tick-paced Moore counting sequencer: go starts/pauses/resumes an up/down count, stop aborts it.
// Define FSM_COUNT_AUTORELOAD_EN to restart the count from DONE instead of returning to IDLE.
module fsm_count_seq #(
  parameter int CLK_DIV    = 1500000,
  parameter int CNT_WIDTH  = 4,
  parameter int MAX_COUNT  = 15,
  parameter int DONE_TICKS = 1
) (
  input  logic           clk,
  input  logic           rst_btn,
  fsm_count_seq_if.slave bus
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int DT_W  = (DONE_TICKS > 1) ? $clog2(DONE_TICKS) : 1;
  localparam logic [CNT_WIDTH-1:0] MAX_VAL   = CNT_WIDTH'(MAX_COUNT);
  localparam logic [DIV_W-1:0]     DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DT_W-1:0]      DONE_LAST = DT_W'(DONE_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COUNTING = 3'd1,
    PAUSED   = 3'd2,
    DONE     = 3'd3
  } state_t;

  logic [DIV_W-1:0]     div;
  logic                 tick;
  logic                 go_s1, go_s2, go_prev;
  logic                 stop_s1, stop_s2, stop_prev;
  logic                 dir_s1, dir_s2;
  logic                 go_req, stop_req;
  logic                 go_hit, stop_hit;
  state_t               state, state_next;
  logic [CNT_WIDTH-1:0] led, led_next;
  logic [CNT_WIDTH-1:0] end_val;
  logic                 dir_lat, dir_lat_next;
  logic [DT_W-1:0]      done_cnt, done_cnt_next;

  assign tick = (div == DIV_LAST);

  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      go_s1     <= 1'b1;
      go_s2     <= 1'b1;
      go_prev   <= 1'b1;
      stop_s1   <= 1'b1;
      stop_s2   <= 1'b1;
      stop_prev <= 1'b1;
      dir_s1    <= 1'b1;
      dir_s2    <= 1'b1;
    end else begin
      go_s1     <= bus.go_btn;
      go_s2     <= go_s1;
      go_prev   <= go_s2;
      stop_s1   <= bus.stop_btn;
      stop_s2   <= stop_s1;
      stop_prev <= stop_s2;
      dir_s1    <= bus.dir;
      dir_s2    <= dir_s1;
    end
  end

  // A press landing on the tick cycle itself is honoured by that tick rather than lost.
  assign go_hit   = go_req   | (go_prev   & ~go_s2);
  assign stop_hit = stop_req | (stop_prev & ~stop_s2);

  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      go_req   <= 1'b0;
      stop_req <= 1'b0;
    end else begin
      go_req   <= tick ? 1'b0 : go_hit;
      stop_req <= tick ? 1'b0 : stop_hit;
    end
  end

  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      state    <= IDLE;
      led      <= '0;
      dir_lat  <= 1'b0;
      done_cnt <= '0;
    end else begin
      state    <= state_next;
      led      <= led_next;
      dir_lat  <= dir_lat_next;
      done_cnt <= done_cnt_next;
    end
  end

  assign end_val = dir_lat ? '0 : MAX_VAL;

  always_comb begin
    state_next    = state;
    led_next      = led;
    dir_lat_next  = dir_lat;
    done_cnt_next = done_cnt;
    if (tick) begin
      case (state)
        IDLE: begin
          if (go_hit) begin
            state_next   = COUNTING;
            dir_lat_next = dir_s2;
            led_next     = dir_s2 ? MAX_VAL : '0;
          end
        end
        COUNTING: begin
          // Stop outranks go, and the end check precedes the step so led never wraps.
          if (stop_hit) begin
            state_next = IDLE;
            led_next   = '0;
          end else if (go_hit) begin
            state_next = PAUSED;
          end else if (led == end_val) begin
            state_next    = DONE;
            done_cnt_next = '0;
          end else begin
            led_next = dir_lat ? (led - CNT_WIDTH'(1)) : (led + CNT_WIDTH'(1));
          end
        end
        PAUSED: begin
          if (stop_hit) begin
            state_next = IDLE;
            led_next   = '0;
          end else if (go_hit) begin
            state_next = COUNTING;
          end
        end
        DONE: begin
`ifdef FSM_COUNT_AUTORELOAD_EN
          if (stop_hit) begin
            state_next = IDLE;
            led_next   = '0;
          end else if (done_cnt == DONE_LAST) begin
            state_next = COUNTING;
            led_next   = dir_lat ? MAX_VAL : '0;
          end else begin
            done_cnt_next = done_cnt + DT_W'(1);
          end
`else
          if (done_cnt == DONE_LAST) begin
            state_next = IDLE;
            led_next   = '0;
          end else begin
            done_cnt_next = done_cnt + DT_W'(1);
          end
`endif
        end
        default: begin
          state_next = IDLE;
          led_next   = '0;
        end
      endcase
    end
  end

  assign bus.led      = led;
  assign bus.done_sig = (state == DONE);
  assign bus.busy     = (state == COUNTING) || (state == PAUSED);

endmodule

// File: tb/tb_fsm_count_seq.sv
// Self-checking bench for fsm_count_seq: hand-derived vector table, corner sequences,
// then randomized buttons compared against a tick-level behavioural model.
module tb_fsm_count_seq;

  localparam int CLK_DIV    = 4;
  localparam int CNT_WIDTH  = 4;
  localparam int MAX_COUNT  = 5;
  localparam int DONE_TICKS = 2;

  localparam int A_NONE = 0;
  localparam int A_GO   = 1;
  localparam int A_STOP = 2;
  localparam int A_BOTH = 3;

  logic clk = 1'b0;
  logic rst_btn;

  fsm_count_seq_if #(.CNT_WIDTH(CNT_WIDTH)) bus ();

  fsm_count_seq #(
    .CLK_DIV   (CLK_DIV),
    .CNT_WIDTH (CNT_WIDTH),
    .MAX_COUNT (MAX_COUNT),
    .DONE_TICKS(DONE_TICKS)
  ) dut (
    .clk    (clk),
    .rst_btn(rst_btn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef enum {M_IDLE, M_COUNT, M_PAUSE, M_DONE} mphase_t;

  mphase_t m_phase;
  int      m_led;
  bit      m_down;
  int      m_done_left;
  int      m_edges;
  bit      m_go_pend, m_stop_pend, m_last_tick;
  bit      hist_go[$], hist_stop[$], hist_dir[$];
  bit      dir_cur;

  typedef struct {
    string name;
    int    action;
    bit    dir;
    int    ticks;
    int    led;
    bit    done_e;
    bit    busy;
  } vec_t;

  vec_t vecs[$];

  function automatic void model_reset();
    m_phase     = M_IDLE;
    m_led       = 0;
    m_down      = 1'b0;
    m_done_left = 0;
    m_edges     = 0;
    m_go_pend   = 1'b0;
    m_stop_pend = 1'b0;
    m_last_tick = 1'b0;
    hist_go     = '{1'b1, 1'b1, 1'b1};
    hist_stop   = '{1'b1, 1'b1, 1'b1};
    hist_dir    = '{1'b1, 1'b1, 1'b1};
  endfunction

  // Histories hold the raw inputs of the last three edges; the FSM sees them two edges late.
  function automatic void model_edge();
    bit go_fall, stop_fall, dir_seen, tick;
    go_fall   = hist_go[$-2] && !hist_go[$-1];
    stop_fall = hist_stop[$-2] && !hist_stop[$-1];
    dir_seen  = hist_dir[$-1];
    m_go_pend   = m_go_pend | go_fall;
    m_stop_pend = m_stop_pend | stop_fall;
    tick = (m_edges % CLK_DIV) == (CLK_DIV - 1);
    if (tick) begin
      case (m_phase)
        M_IDLE: if (m_go_pend) begin
          m_phase = M_COUNT;
          m_down  = dir_seen;
          m_led   = m_down ? MAX_COUNT : 0;
        end
        M_COUNT: begin
          if (m_stop_pend) begin
            m_phase = M_IDLE;
            m_led   = 0;
          end else if (m_go_pend) begin
            m_phase = M_PAUSE;
          end else if (m_led == (m_down ? 0 : MAX_COUNT)) begin
            m_phase     = M_DONE;
            m_done_left = DONE_TICKS;
          end else begin
            m_led = m_down ? m_led - 1 : m_led + 1;
          end
        end
        M_PAUSE: begin
          if (m_stop_pend) begin
            m_phase = M_IDLE;
            m_led   = 0;
          end else if (m_go_pend) begin
            m_phase = M_COUNT;
          end
        end
        M_DONE: begin
          m_done_left = m_done_left - 1;
`ifdef FSM_COUNT_AUTORELOAD_EN
          if (m_stop_pend) begin
            m_phase = M_IDLE;
            m_led   = 0;
          end else if (m_done_left == 0) begin
            m_phase = M_COUNT;
            m_led   = m_down ? MAX_COUNT : 0;
          end
`else
          if (m_done_left == 0) begin
            m_phase = M_IDLE;
            m_led   = 0;
          end
`endif
        end
        default: m_phase = M_IDLE;
      endcase
      m_go_pend   = 1'b0;
      m_stop_pend = 1'b0;
    end
    m_last_tick = tick;
    hist_go.push_back(bus.go_btn);
    hist_stop.push_back(bus.stop_btn);
    hist_dir.push_back(bus.dir);
    void'(hist_go.pop_front());
    void'(hist_stop.pop_front());
    void'(hist_dir.pop_front());
    m_edges++;
  endfunction

  task automatic applyStimulus(input bit go, input bit stop, input bit d);
    bus.go_btn   = go;
    bus.stop_btn = stop;
    bus.dir      = d;
    dir_cur      = d;
  endtask

  task automatic checkOutput(input string name, input int exp_led, input bit exp_done, input bit exp_busy);
    tests_run++;
    if (bus.led !== CNT_WIDTH'(exp_led) || bus.done_sig !== exp_done || bus.busy !== exp_busy) begin
      tests_failed++;
      $display("[TB] FAIL %s: got led=%0d done=%0b busy=%0b, expected led=%0d done=%0b busy=%0b",
               name, bus.led, bus.done_sig, bus.busy, exp_led, exp_done, exp_busy);
    end
  endtask

  task automatic run_cycle();
    @(posedge clk);
    if (!rst_btn) model_reset();
    else model_edge();
    @(negedge clk);
  endtask

  task automatic run_to_tick();
    int n = 0;
    do begin
      run_cycle();
      n++;
    end while (!m_last_tick && n < 4 * CLK_DIV);
    if (!m_last_tick) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL tick_wait: no tick within %0d cycles", n);
    end
  endtask

  // Presses start right after a tick so the FSM acts on them at the very next tick.
  task automatic press(input bit go, input bit stop, input bit d);
    if (!m_last_tick) run_to_tick();
    applyStimulus(!go, !stop, d);
    run_cycle();
    applyStimulus(1'b1, 1'b1, d);
    run_to_tick();
  endtask

  function automatic void add(input string name, input int action, input bit d, input int ticks,
                              input int led, input bit done_e, input bit busy);
    vec_t v;
    v.name = name; v.action = action; v.dir = d; v.ticks = ticks;
    v.led = led; v.done_e = done_e; v.busy = busy;
    vecs.push_back(v);
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    add("up_start", A_GO, 0, 0, 0, 0, 1);
    for (int i = 1; i <= MAX_COUNT; i++) add("up_step", A_NONE, 0, 1, i, 0, 1);
    add("up_done1", A_NONE, 0, 1, MAX_COUNT, 1, 0);
    add("up_done2", A_NONE, 0, 1, MAX_COUNT, 1, 0);
    add("up_idle",  A_NONE, 0, 1, 0, 0, 0);
    add("dn_start", A_GO, 1, 0, MAX_COUNT, 0, 1);
    for (int i = MAX_COUNT - 1; i >= 0; i--) add("dn_step_dirflip", A_NONE, i[0], 1, i, 0, 1);
    add("dn_done1", A_NONE, 0, 1, 0, 1, 0);
    add("dn_done2", A_NONE, 0, 1, 0, 1, 0);
    add("dn_idle",  A_NONE, 0, 1, 0, 0, 0);
    add("ps_start",  A_GO,   0, 0, 0, 0, 1);
    add("ps_run",    A_NONE, 0, 2, 2, 0, 1);
    add("ps_pause",  A_GO,   0, 0, 2, 0, 1);
    add("ps_hold",   A_NONE, 0, 10, 2, 0, 1);
    add("ps_resume", A_GO,   0, 0, 2, 0, 1);
    add("ps_step",   A_NONE, 0, 1, 3, 0, 1);
    add("ps_stop",   A_STOP, 0, 0, 0, 0, 0);
    add("gs_start",  A_GO,   0, 0, 0, 0, 1);
    add("gs_step",   A_NONE, 0, 1, 1, 0, 1);
    add("gs_both",   A_BOTH, 0, 0, 0, 0, 0);
    add("gs_stay",   A_NONE, 0, 3, 0, 0, 0);
    add("dg_start",  A_GO,   0, 0, 0, 0, 1);
    add("dg_run",    A_NONE, 0, MAX_COUNT, MAX_COUNT, 0, 1);
    add("dg_done",   A_NONE, 0, 1, MAX_COUNT, 1, 0);
    add("dg_go_ign", A_GO,   0, 0, MAX_COUNT, 1, 0);
    add("dg_idle",   A_NONE, 0, 1, 0, 0, 0);
    add("dg_stay",   A_NONE, 0, 2, 0, 0, 0);

    rst_btn = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0);
    model_reset();
    run_cycle();
    run_cycle();
    checkOutput("reset_state", 0, 0, 0);
    rst_btn = 1'b1;

    foreach (vecs[i]) begin
      case (vecs[i].action)
        A_GO:    press(1'b1, 1'b0, vecs[i].dir);
        A_STOP:  press(1'b0, 1'b1, vecs[i].dir);
        A_BOTH:  press(1'b1, 1'b1, vecs[i].dir);
        default: applyStimulus(1'b1, 1'b1, vecs[i].dir);
      endcase
      for (int t = 0; t < vecs[i].ticks; t++) run_to_tick();
      checkOutput(vecs[i].name, vecs[i].led, vecs[i].done_e, vecs[i].busy);
    end

    // Reset pulse mid-count, with a go press still inside the synchroniser.
    press(1'b1, 1'b0, 1'b0);
    for (int t = 0; t < 3; t++) run_to_tick();
    checkOutput("rst_pre", 3, 0, 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    run_cycle();
    rst_btn = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0);
    model_reset();
    #1;
    checkOutput("rst_async", 0, 0, 0);
    run_cycle();
    rst_btn = 1'b1;
    run_to_tick();
    run_to_tick();
    checkOutput("rst_no_pend", 0, 0, 0);

    for (int i = 0; i < 4000; i++) begin
      bit go, stop, d;
      go   = ($urandom_range(0, 99) < 4) ? 1'b0 : 1'b1;
      stop = ($urandom_range(0, 99) < 1) ? 1'b0 : 1'b1;
      d    = ($urandom_range(0, 19) == 0) ? ~dir_cur : dir_cur;
      if ($urandom_range(0, 799) == 0) begin
        rst_btn = 1'b0;
        model_reset();
        #1;
        checkOutput("rand_rst", 0, 0, 0);
        run_cycle();
        rst_btn = 1'b1;
      end
      applyStimulus(go, stop, d);
      run_cycle();
      checkOutput("rand", m_led, m_phase == M_DONE, m_phase == M_COUNT || m_phase == M_PAUSE);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
